// File: rtl/free_list_pkg.sv
// Shared sizing and types for the multi-wide physical register free list.
package free_list_pkg;

    localparam int DEF_NUM_PR   = 64;
    localparam int DEF_NUM_AR   = 32;
    localparam int DEF_ALLOC_W  = 2;
    localparam int DEF_FREE_W   = 2;
    localparam int DEF_NUM_CKPT = 4;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_PRW = idx_w(DEF_NUM_PR);
    localparam int DEF_CKW = idx_w(DEF_NUM_CKPT);

    // Head/tail pointer at default sizing: PR index plus one wrap bit.
    typedef logic [DEF_PRW:0] ptr_t;

endpackage

// File: rtl/free_list_ckpt.sv
// Branch checkpoint FIFO: snapshots of the free-list head, allocated youngest+1,
// released oldest-first, and truncated back to a mispredicted checkpoint on recover.
module free_list_ckpt
    import free_list_pkg::*;
#(
    parameter int NUM_CKPT = DEF_NUM_CKPT,
    parameter int CKW      = DEF_CKW,
    parameter int HW       = DEF_PRW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           take,
    input  logic [HW-1:0]  snap_head,
    input  logic           ckpt_release,
    input  logic           recover,
    input  logic [CKW-1:0] recover_id,
    output logic [CKW-1:0] ckpt_id,
    output logic           ckpt_full,
    output logic [HW-1:0]  recover_head
);
    typedef logic [CKW:0] cnt_t;

    logic [CKW-1:0] oldest;
    cnt_t           live;
    cnt_t           oldest_w;
    cnt_t           rec_w;
    cnt_t           id_sum;
    cnt_t           rec_dist;
    logic           rel_en;
    logic [HW-1:0]  snap [NUM_CKPT];

    function automatic logic [CKW-1:0] inc(input logic [CKW-1:0] v);
        return (v == CKW'(NUM_CKPT - 1)) ? '0 : v + CKW'(1);
    endfunction

    assign oldest_w = {1'b0, oldest};
    assign rec_w    = {1'b0, recover_id};
    assign id_sum   = oldest_w + live;
    assign ckpt_id  = (id_sum >= cnt_t'(NUM_CKPT)) ? CKW'(id_sum - cnt_t'(NUM_CKPT))
                                                   : id_sum[CKW-1:0];
    assign ckpt_full = (live == cnt_t'(NUM_CKPT));

    // Number of live checkpoints older than recover_id; these survive a recover.
    assign rec_dist = (rec_w >= oldest_w) ? (rec_w - oldest_w)
                                          : (rec_w + cnt_t'(NUM_CKPT) - oldest_w);

    // A release during recover only applies when the oldest is not itself discarded.
    assign rel_en = ckpt_release && (live != '0) && (!recover || (rec_dist != '0));

    assign recover_head = snap[recover_id];

    always_ff @(posedge clk) begin
        if (!rst) begin
            oldest <= '0;
            live   <= '0;
        end else begin
            if (rel_en) begin
                oldest <= inc(oldest);
            end
            if (recover) begin
                live <= rec_dist - cnt_t'(rel_en);
            end else begin
                live <= live + cnt_t'(take) - cnt_t'(rel_en);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && take) begin
            snap[ckpt_id] <= snap_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && recover) begin
            assert (rec_dist < live);
        end
    end

endmodule

// File: rtl/free_list_mw.sv
// Multi-wide physical register free list with head checkpoints for branch recovery.
// NUM_PR must be a power of two so the wrap-bit pointers index the array directly.
module free_list_mw
    import free_list_pkg::*;
#(
    parameter int  NUM_PR   = DEF_NUM_PR,
    parameter int  NUM_AR   = DEF_NUM_AR,
    parameter int  ALLOC_W  = DEF_ALLOC_W,
    parameter int  FREE_W   = DEF_FREE_W,
    parameter int  NUM_CKPT = DEF_NUM_CKPT,
    localparam int PRW      = idx_w(NUM_PR),
    localparam int CKW      = idx_w(NUM_CKPT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALLOC_W-1:0]     alloc_req,
    input  logic                   stall,
    output logic [ALLOC_W*PRW-1:0] alloc_pr,
    output logic                   alloc_ok,
    input  logic [FREE_W-1:0]      free_vld,
    input  logic [FREE_W*PRW-1:0]  free_pr,
    input  logic                   ckpt_take,
    output logic [CKW-1:0]         ckpt_id,
    output logic                   ckpt_full,
    input  logic                   ckpt_release,
    input  logic                   recover,
    input  logic [CKW-1:0]         recover_id,
    output logic [PRW:0]           free_count
);
    typedef logic [PRW:0] cnt_t;

    logic [PRW-1:0] mem [NUM_PR];
    logic [PRW-1:0] free_idx [FREE_W];
    cnt_t           head;
    cnt_t           tail;
    cnt_t           head_alloc;
    cnt_t           head_next;
    cnt_t           tail_next;
    cnt_t           alloc_cnt;
    cnt_t           free_cnt;
    cnt_t           recover_head;
    logic           fire;
    logic           take_en;

    assign free_count = tail - head;

    // Each requested slot reads the entry after those claimed by lower slots.
    always_comb begin
        alloc_cnt = '0;
        alloc_pr  = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_pr[i*PRW +: PRW] = mem[head[PRW-1:0] + alloc_cnt[PRW-1:0]];
            if (alloc_req[i]) begin
                alloc_cnt = alloc_cnt + cnt_t'(1);
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int k = 0; k < FREE_W; k++) begin
            free_idx[k] = tail[PRW-1:0] + free_cnt[PRW-1:0];
            if (free_vld[k]) begin
                free_cnt = free_cnt + cnt_t'(1);
            end
        end
    end

    assign alloc_ok   = (free_count >= alloc_cnt);
    assign fire       = (|alloc_req) & alloc_ok & ~stall & ~recover;
    assign take_en    = ckpt_take & ~stall & ~ckpt_full & ~recover;
    assign head_alloc = fire ? (head + alloc_cnt) : head;
    assign head_next  = recover ? recover_head : head_alloc;
    assign tail_next  = tail + free_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= cnt_t'(NUM_PR - NUM_AR);
            for (int i = 0; i < NUM_PR; i++) begin
                mem[i] <= (i < NUM_PR - NUM_AR) ? PRW'(NUM_AR + i) : '0;
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int k = 0; k < FREE_W; k++) begin
                if (free_vld[k]) begin
                    mem[free_idx[k]] <= free_pr[k*PRW +: PRW];
                end
            end
        end
    end

    // More than NUM_PR free entries means a PR was returned twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ((tail_next - head_next) <= cnt_t'(NUM_PR));
        end
    end

    free_list_ckpt #(
        .NUM_CKPT (NUM_CKPT),
        .CKW      (CKW),
        .HW       (PRW + 1)
    ) u_ckpt (
        .clk          (clk),
        .rst          (rst),
        .take         (take_en),
        .snap_head    (head_alloc),
        .ckpt_release (ckpt_release),
        .recover      (recover),
        .recover_id   (recover_id),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .recover_head (recover_head)
    );

endmodule

// File: tb/tb_free_list_mw.sv
// Directed and randomized checks of free_list_mw against a queue-based model of
// free PRs, allocation history and checkpoints.
module tb_free_list_mw;
    localparam int PRW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_req;
    logic        stall;
    logic [11:0] alloc_pr;
    logic        alloc_ok;
    logic [1:0]  free_vld;
    logic [11:0] free_pr;
    logic        ckpt_take;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        ckpt_release;
    logic        recover;
    logic [1:0]  recover_id;
    logic [6:0]  free_count;

    int checks   = 0;
    int failures = 0;

    typedef struct { int id; int snap; } ck_t;
    int  free_q[$];
    int  hist[$];
    int  retire_q[$];
    ck_t ck_q[$];
    int  moved;
    int  next_id;
    bit  model_valid = 1'b0;

    always #5 clk = ~clk;

    free_list_mw dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .stall        (stall),
        .alloc_pr     (alloc_pr),
        .alloc_ok     (alloc_ok),
        .free_vld     (free_vld),
        .free_pr      (free_pr),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .ckpt_release (ckpt_release),
        .recover      (recover),
        .recover_id   (recover_id),
        .free_count   (free_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        free_q.delete();
        hist.delete();
        retire_q.delete();
        ck_q.delete();
        for (int i = 32; i < 64; i++) free_q.push_back(i);
        for (int i = 0; i < 32; i++) retire_q.push_back(i);
        moved   = 0;
        next_id = 0;
    endfunction

    task automatic check_model();
        int pc;
        pc = 0;
        if (!model_valid) return;
        for (int i = 0; i < 2; i++) begin
            if (alloc_req[i]) begin
                if (pc < free_q.size())
                    chk($sformatf("alloc_pr%0d", i), 32'(alloc_pr[i*PRW +: PRW]), free_q[pc]);
                pc++;
            end
        end
        chk("alloc_ok", 32'(alloc_ok), 32'(free_q.size() >= pc));
        chk("free_count", 32'(free_count), free_q.size());
        chk("ckpt_full", 32'(ckpt_full), 32'(ck_q.size() == 4));
        chk("ckpt_id", 32'(ckpt_id), next_id);
    endtask

    task automatic apply(input logic [1:0] ar, input logic st, input logic [1:0] fv,
                         input int f0, input int f1, input logic tk, input logic rl,
                         input logic rc, input int rid, input logic rs);
        @(negedge clk);
        rst          = rs;
        alloc_req    = ar;
        stall        = st;
        free_vld     = fv;
        free_pr      = {6'(f1), 6'(f0)};
        ckpt_take    = tk;
        ckpt_release = rl;
        recover      = rc;
        recover_id   = 2'(rid);
        #1;
        check_model();
    endtask

    task automatic tick();
        int  pc, p, snap, pr, committed;
        int  idx[$];
        bit  full0, rel;
        @(posedge clk);
        if (!rst) begin
            model_reset();
            model_valid = 1'b1;
            return;
        end
        pc    = $countones(alloc_req);
        full0 = (ck_q.size() == 4);
        if (recover) begin
            p = 0;
            foreach (ck_q[j]) if (ck_q[j].id == int'(recover_id)) p = j;
            snap = ck_q[p].snap;
            while (hist.size() > snap) free_q.push_front(hist.pop_back());
            if (ckpt_release && p > 0) begin
                void'(ck_q.pop_front());
                p--;
            end
            while (ck_q.size() > p) void'(ck_q.pop_back());
            next_id = recover_id;
        end else begin
            rel = ckpt_release && ck_q.size() > 0;
            if (|alloc_req && free_q.size() >= pc && !stall)
                repeat (pc) hist.push_back(free_q.pop_front());
            if (rel) void'(ck_q.pop_front());
            if (ckpt_take && !stall && !full0) begin
                ck_q.push_back(ck_t'{next_id, hist.size()});
                next_id = (next_id + 1) % 4;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (free_vld[k]) begin
                pr  = free_pr[k*PRW +: PRW];
                idx = retire_q.find_first_index(item) with (item == pr);
                if (idx.size() > 0) retire_q.delete(idx[0]);
                free_q.push_back(pr);
            end
        end
        // PRs allocated before the oldest live checkpoint can no longer be rolled back.
        committed = (ck_q.size() > 0) ? ck_q[0].snap : hist.size();
        while (moved < committed) begin
            retire_q.push_back(hist[moved]);
            moved++;
        end
    endtask

    task automatic reset_dut();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic alloc_cycle(input logic [1:0] ar);
        apply(ar, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    initial begin
        logic [1:0] ar, fv;
        logic       st, tk, rl, rc;
        int         f0, f1, rid, i0, i1;

        // Reset, then a two-wide allocation.
        reset_dut();
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r36_pr0", 32'(alloc_pr[5:0]), 32);
        chk("r36_pr1", 32'(alloc_pr[11:6]), 33);
        chk("r36_cnt0", 32'(free_count), 32);
        tick();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r36_cnt1", 32'(free_count), 30);
        tick();

        // Drain to a single free entry.
        repeat (14) alloc_cycle(2'b11);
        alloc_cycle(2'b01);
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r37_ok_short", 32'(alloc_ok), 0);
        tick();
        apply(2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r37_cnt_held", 32'(free_count), 1);
        chk("r37_ok_one", 32'(alloc_ok), 1);
        chk("r37_pr_last", 32'(alloc_pr[5:0]), 63);
        tick();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r37_cnt_empty", 32'(free_count), 0);
        tick();

        // Same-cycle free and allocate.
        reset_dut();
        apply(2'b11, 0, 2'b11, 5, 7, 0, 0, 0, 0, 1);
        tick();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r38_cnt_same", 32'(free_count), 32);
        tick();
        repeat (15) alloc_cycle(2'b11);
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r38_pr0", 32'(alloc_pr[5:0]), 5);
        chk("r38_pr1", 32'(alloc_pr[11:6]), 7);
        tick();

        // Checkpoint, speculative allocations, a free, then recover.
        reset_dut();
        apply(2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
        chk("r39_id", 32'(ckpt_id), 0);
        tick();
        alloc_cycle(2'b11);
        alloc_cycle(2'b01);
        apply(2'b00, 0, 2'b01, 3, 0, 0, 0, 0, 0, 1);
        tick();
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        tick();
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r39_cnt", 32'(free_count), 33);
        chk("r39_pr0", 32'(alloc_pr[5:0]), 32);
        chk("r39_pr1", 32'(alloc_pr[11:6]), 33);
        tick();

        // Fill all checkpoints, overflow take, partial recover.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            apply(2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
            chk("r40_id", 32'(ckpt_id), i);
            chk("r40_not_full", 32'(ckpt_full), 0);
            tick();
        end
        apply(2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
        chk("r40_full", 32'(ckpt_full), 1);
        tick();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1);
        chk("r40_still_full", 32'(ckpt_full), 1);
        tick();
        apply(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r40_next_id", 32'(ckpt_id), 1);
        chk("r40_after_full", 32'(ckpt_full), 0);
        tick();

        // Reset wins over recover, alloc, take and free.
        reset_dut();
        apply(2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
        tick();
        alloc_cycle(2'b11);
        apply(2'b11, 0, 2'b01, 9, 0, 1, 0, 1, 0, 0);
        tick();
        apply(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("r41_cnt", 32'(free_count), 32);
        chk("r41_full", 32'(ckpt_full), 0);
        chk("r41_id", 32'(ckpt_id), 0);
        chk("r41_pr0", 32'(alloc_pr[5:0]), 32);
        chk("r41_pr1", 32'(alloc_pr[11:6]), 33);
        tick();

        // Randomized traffic; frees only return PRs no live checkpoint can reclaim.
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            ar = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 7) == 0);
            fv = 2'b00;
            f0 = 0;
            f1 = 0;
            if (retire_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                i0    = $urandom_range(0, retire_q.size() - 1);
                f0    = retire_q[i0];
                fv[0] = 1'b1;
                if (retire_q.size() > 1 && $urandom_range(0, 1) == 1) begin
                    i1    = (i0 + 1 + $urandom_range(0, retire_q.size() - 2)) % retire_q.size();
                    f1    = retire_q[i1];
                    fv[1] = 1'b1;
                end
            end
            tk  = ($urandom_range(0, 3) == 0);
            rl  = (ck_q.size() > 0) && ($urandom_range(0, 5) == 0);
            rc  = 1'b0;
            rid = 0;
            if (ck_q.size() > 0 && $urandom_range(0, 9) == 0) begin
                rc  = 1'b1;
                rid = ck_q[$urandom_range(0, ck_q.size() - 1)].id;
            end
            apply(ar, st, fv, f0, f1, tk, rl, rc, rid, 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/free_list_mw.md
FREE_LIST_MW -- requirements
Module: free_list_mw

Interface
REQ-001 SHALL have parameter NUM_PR, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_AR, default 32, architectural registers; PR 0..NUM_AR-1 are mapped at reset.
REQ-003 SHALL have parameter ALLOC_W, default 2, allocation slots per cycle.
REQ-004 SHALL have parameter FREE_W, default 2, retire free ports per cycle.
REQ-005 SHALL have parameter NUM_CKPT, default 4, branch checkpoints; PRW=clog2(NUM_PR), CKW=clog2(NUM_CKPT).
REQ-006 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port alloc_req  input  ALLOC_W  per-slot request for a new PR, decode order.
REQ-009 SHALL have port stall  input  1  hazard stall; blocks allocation and checkpoint take.
REQ-010 SHALL have port alloc_pr  output  ALLOC_W*PRW  PR granted per slot.
REQ-011 SHALL have port alloc_ok  output  1  free entries cover popcount(alloc_req).
REQ-012 SHALL have port free_vld  input  FREE_W  per-port retire free valid.
REQ-013 SHALL have port free_pr  input  FREE_W*PRW  stale PR to return.
REQ-014 SHALL have port ckpt_take  input  1  snapshot head for a branch.
REQ-015 SHALL have port ckpt_id  output  CKW  id assigned to ckpt_take this cycle.
REQ-016 SHALL have port ckpt_full  output  1  no free checkpoint.
REQ-017 SHALL have port ckpt_release  input  1  oldest checkpoint resolved correct.
REQ-018 SHALL have port recover, recover_id  input  1, CKW  mispredict; restore to checkpoint recover_id.
REQ-019 SHALL have port free_count  output  PRW+1  entries currently free.

Function
REQ-020 SHALL store free PRs in an NUM_PR-entry circular array; head/tail pointers PRW+1 bits (wrap bit); free_count = tail-head.
REQ-021 SHALL present alloc_pr[i] combinationally = mem[head + number of set alloc_req bits below i]; unrequested slots don't care.
REQ-022 SHALL allocate only when fire = |alloc_req & alloc_ok & ~stall & ~recover; all-or-nothing; head += popcount(alloc_req).
REQ-023 SHALL write each valid free port, in port order, to mem[tail+k]; tail += popcount(free_vld); frees are never blocked by stall or recover.
REQ-024 SHALL accept frees and allocation in the same cycle; allocation sees only free_count from the start of the cycle.
REQ-025 SHALL never overflow: free_count <= NUM_PR - NUM_AR + ... bounded by NUM_PR; free beyond NUM_PR is an assertion failure.
REQ-026 SHALL, on ckpt_take & ~stall & ~ckpt_full & ~recover, record post-allocation head (this cycle's allocations excluded from recovery) into slot ckpt_id.
REQ-027 SHALL manage checkpoints as a FIFO: ckpt_id = youngest+1 mod NUM_CKPT; ckpt_release frees the oldest; ckpt_full when NUM_CKPT live.
REQ-028 SHALL, on recover, set head <= snapshot[recover_id] and discard recover_id and all younger checkpoints, in one cycle.
REQ-029 SHALL give recover priority over alloc and ckpt_take; same-cycle ckpt_release of an older checkpoint still applies.
REQ-030 SHALL compute free_count after recover as tail_next - snapshot head, including same-cycle frees.
REQ-031 SHALL treat recover_id not live as an assertion failure.

Reset
REQ-032 SHALL on rst=0 at clk edge: mem[i]=NUM_AR+i for i<NUM_PR-NUM_AR, head=0, tail=NUM_PR-NUM_AR, free_count=NUM_PR-NUM_AR, no live checkpoints, ckpt_full=0, ckpt_id=0.
REQ-033 SHALL let reset override every concurrent input, including mid-recovery.

Structure
REQ-034 SHALL place parameter defaults, PRW/CKW derivation and pointer type in shared package free_list_pkg.
REQ-035 SHALL implement the checkpoint FIFO as sub-module free_list_ckpt.

Verification
REQ-036 SHALL test reset then alloc_req=2'b11 -> alloc_pr={33,32}, free_count 32->30 next cycle.
REQ-037 SHALL test drain to free_count=1 with alloc_req=2'b11 -> alloc_ok=0, head unchanged; alloc_req=2'b01 -> granted.
REQ-038 SHALL test free_vld=2'b11 {5,7} with alloc_req=2'b11 same cycle -> free_count unchanged, 5 and 7 allocated after 30 others.
REQ-039 SHALL test ckpt_take (id 0), 3 allocs, 1 free, recover id 0 -> head restored, free_count = snapshot+1, same PRs reissued.
REQ-040 SHALL test 4 ckpt_take -> ckpt_full=1; 5th ignored; recover_id=1 -> ids 1..3 discarded, next ckpt_id=1.
REQ-041 SHALL test rst=0 asserted during recover and alloc -> all state equals REQ-032 values next cycle.
